// File: rtl/guess_pkg.sv
// rtl/guess_pkg.sv - shared state enum, display codes and LED patterns for guess_engine
package guess_pkg;

  typedef enum logic [2:0] {IDLE, READ, CHEAT, WIN, LOSE} state_e;

  localparam logic [3:0] BCD_DASH  = 4'hA;
  localparam logic [3:0] BCD_BLANK = 4'hF;

  localparam logic [15:0] LED_IDLE = 16'h0000;
  localparam logic [15:0] LED_WIN  = 16'hFFFF;
  localparam logic [15:0] LED_LOSE = 16'hAAAA;

  // Largest target: all 9s except the LSD, so the target is never the initial upper bound.
  function automatic logic [15:0] bcd_top_target(input int digits);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < digits) r[4*i +: 4] = 4'h9;
    end
    r[3:0] = 4'h8;
    return r;
  endfunction

  function automatic logic [15:0] led_thermo(input int n);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i] = (i < n);
    return r;
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// rtl/bcd_counter.sv - free-running multi-digit BCD counter wrapping MAX_VAL -> MIN_VAL
module bcd_counter #(
  parameter int                  DIGITS  = 2,
  parameter logic [4*DIGITS-1:0] MIN_VAL = {{(DIGITS-1){4'h0}}, 4'h1},
  parameter logic [4*DIGITS-1:0] MAX_VAL = {DIGITS{4'h9}}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  output logic [4*DIGITS-1:0] count_o
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] count_q, count_d, inc;
  logic         carry;

  always_comb begin
    inc   = count_q;
    carry = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (count_q[4*d +: 4] == 4'h9) begin
          inc[4*d +: 4] = 4'h0;
        end else begin
          inc[4*d +: 4] = count_q[4*d +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    count_d = count_q;
    if (en_i) count_d = (count_q == MAX_VAL) ? MIN_VAL : inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= MIN_VAL;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/guess_engine.sv
// rtl/guess_engine.sv - number-guessing game controller; GUESS_CHEAT_EN adds the CHEAT state
module guess_engine
  import guess_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter int MAX_TRIES   = 7,
  parameter int HOLD_CYCLES = 33554432,
  parameter int TRY_W       = $clog2(MAX_TRIES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                key_valid,
  input  logic [3:0]          key_num,
  input  logic                enter,
  input  logic                cheat,
  output logic [4*DIGITS-1:0] disp_left,
  output logic [4*DIGITS-1:0] disp_right,
  output logic [15:0]         led,
  output logic [TRY_W-1:0]    tries_left,
  output logic                win,
  output logic                lose
);

  localparam int             W         = 4 * DIGITS;
  localparam int             CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [W-1:0]   ALL_DASH  = {DIGITS{BCD_DASH}};
  localparam logic [W-1:0]   ALL_BLANK = {DIGITS{BCD_BLANK}};
  localparam logic [W-1:0]   NINES     = {DIGITS{4'h9}};
  localparam logic [15:0]    TOP16     = bcd_top_target(DIGITS);
  localparam logic [W-1:0]   CTR_MAX   = TOP16[W-1:0];
  localparam logic [W-1:0]   CTR_MIN   = W'(1);
  localparam logic [TRY_W-1:0] TRIES0  = TRY_W'(MAX_TRIES);

  state_e             state_q, state_d;
  logic [W-1:0]       lower_q, lower_d, upper_q, upper_d;
  logic [W-1:0]       entry_q, entry_d, target_q, target_d;
  logic [W-1:0]       dl_q, dl_d, dr_q, dr_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        led_q, led_d;
  logic               win_q, lose_q;
  logic [W-1:0]       ctr_val, guess;
  logic               guess_ok;

  bcd_counter #(
    .DIGITS (DIGITS),
    .MIN_VAL(CTR_MIN),
    .MAX_VAL(CTR_MAX)
  ) u_target_src (
    .clk    (clk),
    .rst_n  (rst),
    .en_i   (1'b1),
    .count_o(ctr_val)
  );

`ifndef GUESS_CHEAT_EN
  logic unused_cheat;
  assign unused_cheat = cheat;
`endif

  // Blank digits of a partial entry read as leading zeros.
  always_comb begin
    guess = '0;
    for (int d = 0; d < DIGITS; d++)
      guess[4*d +: 4] = (entry_q[4*d +: 4] == BCD_BLANK) ? 4'h0 : entry_q[4*d +: 4];
  end

  assign guess_ok = (entry_q != ALL_BLANK) && (guess > lower_q) && (guess < upper_q);

  always_comb begin
    state_d  = state_q;
    lower_d  = lower_q;
    upper_d  = upper_q;
    entry_d  = entry_q;
    target_d = target_q;
    tries_d  = tries_q;
    cnt_d    = cnt_q;
    dl_d     = dl_q;
    dr_d     = dr_q;
    case (state_q)
      IDLE: begin
        lower_d = '0;
        upper_d = NINES;
        tries_d = TRIES0;
        cnt_d   = '0;
        dl_d    = ALL_DASH;
        dr_d    = ALL_DASH;
        if (start) begin
          target_d = ctr_val;
          entry_d  = ALL_BLANK;
          state_d  = READ;
          dl_d     = '0;
          dr_d     = NINES;
        end
      end
      READ: begin
        if (enter) begin
          entry_d = ALL_BLANK;
          dl_d    = lower_q;
          dr_d    = upper_q;
          if (guess_ok) begin
            tries_d = tries_q - TRY_W'(1);
            if (guess == target_q) begin
              state_d = WIN;
              cnt_d   = '0;
              dl_d    = target_q;
              dr_d    = target_q;
            end else begin
              if (guess > target_q) upper_d = guess;
              else                  lower_d = guess;
              if (tries_q == TRY_W'(1)) begin
                state_d = LOSE;
                cnt_d   = '0;
                dl_d    = target_q;
                dr_d    = ALL_DASH;
              end else begin
                dl_d = (guess > target_q) ? lower_q : guess;
                dr_d = (guess > target_q) ? guess : upper_q;
              end
            end
          end
        end else if (key_valid && key_num <= 4'd9) begin
          entry_d = {entry_q[W-5:0], key_num};
          dl_d    = ALL_BLANK;
          dr_d    = {entry_q[W-5:0], key_num};
`ifdef GUESS_CHEAT_EN
        end else if (cheat) begin
          state_d = CHEAT;
          dl_d    = target_q;
          dr_d    = ALL_BLANK;
`endif
        end
      end
`ifdef GUESS_CHEAT_EN
      CHEAT: begin
        if (!cheat) begin
          state_d = READ;
          dl_d    = lower_q;
          dr_d    = upper_q;
        end
      end
`endif
      WIN, LOSE: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          lower_d = '0;
          upper_d = NINES;
          tries_d = TRIES0;
          dl_d    = ALL_DASH;
          dr_d    = ALL_DASH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        dl_d    = ALL_DASH;
        dr_d    = ALL_DASH;
      end
    endcase
  end

  always_comb begin
    led_d = LED_IDLE;
    case (state_d)
      READ, CHEAT: led_d = led_thermo(int'(tries_d));
      WIN:         led_d = LED_WIN;
      LOSE:        led_d = LED_LOSE;
      default:     led_d = LED_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      lower_q  <= '0;
      upper_q  <= NINES;
      entry_q  <= ALL_BLANK;
      target_q <= '0;
      tries_q  <= TRIES0;
      cnt_q    <= '0;
      dl_q     <= ALL_DASH;
      dr_q     <= ALL_DASH;
      led_q    <= LED_IDLE;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lower_q  <= lower_d;
      upper_q  <= upper_d;
      entry_q  <= entry_d;
      target_q <= target_d;
      tries_q  <= tries_d;
      cnt_q    <= cnt_d;
      dl_q     <= dl_d;
      dr_q     <= dr_d;
      led_q    <= led_d;
      win_q    <= (state_d == WIN);
      lose_q   <= (state_d == LOSE);
    end
  end

  assign disp_left  = dl_q;
  assign disp_right = dr_q;
  assign led        = led_q;
  assign tries_left = tries_q;
  assign win        = win_q;
  assign lose       = lose_q;

endmodule

// File: tb/tb_guess_engine.sv
// tb/tb_guess_engine.sv - directed and random checks of guess_engine against a decimal game model
module tb_guess_engine;

  localparam int DIGITS = 2, MAX_TRIES = 3, HOLD_CYCLES = 8;
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
`ifdef GUESS_CHEAT_EN
  localparam bit CHEAT_EN = 1'b1;
`else
  localparam bit CHEAT_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0;
  logic start = 0, key_valid = 0, enter = 0, cheat = 0;
  logic [3:0] key_num = 0;
  logic [7:0] disp_left, disp_right;
  logic [15:0] led;
  logic [TRY_W-1:0] tries_left;
  logic win, lose;

  guess_engine #(.DIGITS(DIGITS), .MAX_TRIES(MAX_TRIES), .HOLD_CYCLES(HOLD_CYCLES)) dut (
    .clk(clk), .rst(rst), .start(start), .key_valid(key_valid), .key_num(key_num),
    .enter(enter), .cheat(cheat), .disp_left(disp_left), .disp_right(disp_right),
    .led(led), .tries_left(tries_left), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Game model in plain decimal: 0 idle, 1 read, 2 cheat, 3 win, 4 lose.
  int m_st, m_lo, m_hi, m_tgt, m_tries, m_hold, m_cnt;
  int m_entry[$];
  logic [7:0] e_dl, e_dr;

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] entry_disp();
    logic [7:0] r;
    r = 8'hFF;
    foreach (m_entry[i]) r = {r[3:0], 4'(m_entry[i])};
    return r;
  endfunction

  task automatic model_reset();
    m_st = 0; m_lo = 0; m_hi = 99; m_tries = MAX_TRIES; m_hold = 0; m_cnt = 1;
    m_entry.delete();
    e_dl = 8'hAA; e_dr = 8'hAA;
  endtask

  task automatic model_step(input bit s, input bit kv, input int kn, input bit en, input bit ch);
    int g;
    bit ok;
    case (m_st)
      0: begin
        m_lo = 0; m_hi = 99; m_tries = MAX_TRIES; e_dl = 8'hAA; e_dr = 8'hAA;
        if (s) begin
          m_tgt = m_cnt; m_st = 1; m_entry.delete();
          e_dl = bcd2(0); e_dr = bcd2(99);
        end
      end
      1: begin
        if (en) begin
          g = 0;
          foreach (m_entry[i]) g = g * 10 + m_entry[i];
          ok = (m_entry.size() > 0) && g > m_lo && g < m_hi;
          m_entry.delete();
          e_dl = bcd2(m_lo); e_dr = bcd2(m_hi);
          if (ok) begin
            m_tries--;
            if (g == m_tgt) begin
              m_st = 3; m_hold = 0; e_dl = bcd2(m_tgt); e_dr = bcd2(m_tgt);
            end else begin
              if (g > m_tgt) m_hi = g; else m_lo = g;
              if (m_tries == 0) begin
                m_st = 4; m_hold = 0; e_dl = bcd2(m_tgt); e_dr = 8'hAA;
              end else begin
                e_dl = bcd2(m_lo); e_dr = bcd2(m_hi);
              end
            end
          end
        end else if (kv && kn <= 9) begin
          m_entry.push_back(kn);
          if (m_entry.size() > DIGITS) void'(m_entry.pop_front());
          e_dl = 8'hFF; e_dr = entry_disp();
        end else if (CHEAT_EN && ch) begin
          m_st = 2; e_dl = bcd2(m_tgt); e_dr = 8'hFF;
        end
      end
      2: if (!ch) begin
        m_st = 1; e_dl = bcd2(m_lo); e_dr = bcd2(m_hi);
      end
      default: begin
        m_hold++;
        if (m_hold == HOLD_CYCLES) begin
          m_st = 0; e_dl = 8'hAA; e_dr = 8'hAA; m_lo = 0; m_hi = 99; m_tries = MAX_TRIES;
        end
      end
    endcase
    m_cnt = (m_cnt == 98) ? 1 : m_cnt + 1;
  endtask

  function automatic logic [15:0] exp_led();
    case (m_st)
      1, 2: return 16'((1 << m_tries) - 1);
      3: return 16'hFFFF;
      4: return 16'hAAAA;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic cycle(input bit s, input bit kv, input int kn, input bit en, input bit ch);
    start = s; key_valid = kv; key_num = 4'(kn); enter = en; cheat = ch;
    @(posedge clk); #1;
    model_step(s, kv, kn, en, ch);
    start = 0; key_valid = 0; enter = 0;
    check("disp_left", 32'(disp_left), 32'(e_dl));
    check("disp_right", 32'(disp_right), 32'(e_dr));
    check("led", 32'(led), 32'(exp_led()));
    check("tries_left", 32'(tries_left), 32'(m_tries));
    check("win", 32'(win), 32'(m_st == 3));
    check("lose", 32'(lose), 32'(m_st == 4));
  endtask

  task automatic key(input int k);
    cycle(0, 1, k, 0, cheat);
  endtask

  task automatic guess2(input int v);
    key(v / 10); key(v % 10); cycle(0, 0, 0, 1, cheat);
  endtask

  task automatic start_at(input int v);
    for (int i = 0; i < 120 && m_cnt != v; i++) cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
  endtask

  int r;
  bit chl;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_disp", 32'({disp_left, disp_right}), 32'h0000AAAA);
    check("rst_led", 32'(led), 32'h0);
    check("rst_tries", 32'(tries_left), 32'd3);
    check("rst_winlose", 32'({win, lose}), 32'h0);
    rst = 1'b1;

    // Win game at target 42.
    start_at(42);
    check("start_disp", 32'({disp_left, disp_right}), 32'h0099);
    check("start_led", 32'(led), 32'h0007);
    guess2(50);
    check("g50_disp", 32'({disp_left, disp_right}), 32'h0050);
    check("g50_tries", 32'(tries_left), 32'd2);
    guess2(42);
    check("win_flag", 32'(win), 32'd1);
    check("win_disp", 32'({disp_left, disp_right}), 32'h4242);
    for (int i = 0; i < HOLD_CYCLES - 1; i++) cycle(0, 0, 0, 0, 0);
    check("win_hold", 32'(win), 32'd1);
    cycle(0, 0, 0, 0, 0);
    check("win_idle", 32'({disp_left, disp_right}), 32'hAAAA);

    // Lose game.
    start_at(42);
    guess2(10);
    check("l10", 32'({disp_left, disp_right}), 32'h1099);
    guess2(90);
    check("l90", 32'({disp_left, disp_right}), 32'h1090);
    guess2(30);
    check("lose_disp", 32'({disp_left, disp_right}), 32'h42AA);
    check("lose_led", 32'(led), 32'hAAAA);
    check("lose_flag", 32'(lose), 32'd1);
    for (int i = 0; i < HOLD_CYCLES; i++) cycle(0, 0, 0, 0, 0);
    check("lose_idle", 32'({disp_left, disp_right}), 32'hAAAA);

    // Invalid guesses and the key+enter collision.
    start_at(42);
    cycle(0, 0, 0, 1, 0);
    check("inv_empty", 32'(tries_left), 32'd3);
    guess2(0);
    check("inv_00", 32'(tries_left), 32'd3);
    guess2(99);
    check("inv_99", 32'(tries_left), 32'd3);
    check("inv_99_disp", 32'({disp_left, disp_right}), 32'h0099);
    guess2(20);
    guess2(20);
    check("inv_bound", 32'(tries_left), 32'd2);
    check("inv_bound_disp", 32'({disp_left, disp_right}), 32'h2099);
    key(7); key(3); cycle(0, 1, 5, 1, 0);
    check("collide_disp", 32'({disp_left, disp_right}), 32'h2073);
    check("collide_tries", 32'(tries_left), 32'd1);

    // Asynchronous reset mid-game.
    key(5);
    rst = 1'b0;
    #1;
    check("arst_disp", 32'({disp_left, disp_right}), 32'hAAAA);
    check("arst_led", 32'(led), 32'h0);
    check("arst_tries", 32'(tries_left), 32'd3);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    start_at(42);
    check("restart_disp", 32'({disp_left, disp_right}), 32'h0099);

`ifdef GUESS_CHEAT_EN
    key(6);
    cycle(0, 0, 0, 0, 1);
    check("cheat_disp", 32'({disp_left, disp_right}), 32'h42FF);
    cycle(0, 1, 5, 0, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 0);
    check("uncheat_disp", 32'({disp_left, disp_right}), 32'h0099);
    cycle(0, 0, 0, 1, 0);
    check("cheat_entry", 32'({disp_left, disp_right}), 32'h0699);
    check("cheat_tries", 32'(tries_left), 32'd2);
`endif

    // Random play.
    chl = 0;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 99) < 3) chl = ~chl;
      if (r < 6) cycle(1, $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1), chl);
      else if (r < 50) cycle(0, 1, $urandom_range(0, 11), 0, chl);
      else if (r < 62) cycle(0, 0, 0, 1, chl);
      else if (r < 66) cycle(0, 1, $urandom_range(0, 9), 1, chl);
      else if (r < 70 && m_st == 1) guess2(m_tgt);
      else cycle(0, 0, 0, 0, chl);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
